// File: rtl/weight_bank_loader_l10_l16.sv
// Write-side loader for the conv8..conv12 weight banks: packs a stream of beats into one
// bank image and commits it atomically so the read mux never sees a partial image.
module weight_bank_loader_l10_l16 #(
    parameter int unsigned N_weight_out = 256,
    parameter int unsigned IN_LANES     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    input  logic [2:0]                   cmd_u,
    output logic                         cmd_ready,
    input  logic                         in_valid,
    input  logic [IN_LANES*16-1:0]       in_data,
    output logic                         in_ready,
    input  logic                         abort,
    input  logic [4:0]                   clear_valid,
    output logic [N_weight_out*16-1:0]   weight_out_conv8,
    output logic [N_weight_out*16-1:0]   weight_out_conv9,
    output logic [N_weight_out*16-1:0]   weight_out_conv10,
    output logic [N_weight_out*16-1:0]   weight_out_conv11,
    output logic [N_weight_out*16-1:0]   weight_out_conv12,
    output logic [4:0]                   bank_valid,
    output logic                         busy,
    output logic                         load_done,
    output logic                         cmd_err
);
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned N_BANKS = 5;
    localparam int unsigned BEATS   = N_weight_out / IN_LANES;
    localparam int unsigned BEAT_W  = IN_LANES * WORD_W;
    localparam int unsigned BANK_W  = N_weight_out * WORD_W;
    localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_e;

    state_e              state_q, state_d;
    logic [2:0]          u_q, u_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [BANK_W-1:0]   pack_q, pack_d;
    logic [BANK_W-1:0]   bank_q [N_BANKS];
    logic [BANK_W-1:0]   bank_d [N_BANKS];
    logic [4:0]          bank_valid_q, bank_valid_d;
    logic                load_done_q, load_done_d;
    logic                cmd_err_q, cmd_err_d;

    logic cmd_fire, cmd_ok, beat_fire, last_beat;

    assign cmd_ready = (state_q == S_IDLE);
    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q != S_IDLE);
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign cmd_ok    = (cmd_u <= 3'd4);
    assign beat_fire = in_valid & in_ready;
    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

    assign weight_out_conv8  = bank_q[0];
    assign weight_out_conv9  = bank_q[1];
    assign weight_out_conv10 = bank_q[2];
    assign weight_out_conv11 = bank_q[3];
    assign weight_out_conv12 = bank_q[4];
    assign bank_valid        = bank_valid_q;
    assign load_done         = load_done_q;
    assign cmd_err           = cmd_err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over a coincident last beat
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cmd_fire && cmd_ok) state_d = S_LOAD;
            S_LOAD: begin
                if (abort)                       state_d = S_IDLE;
                else if (beat_fire && last_beat) state_d = S_COMMIT;
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next values; a commit overrides a same-cycle clear of its own bank_valid bit
    always_comb begin
        u_d          = u_q;
        beat_cnt_d   = beat_cnt_q;
        pack_d       = pack_q;
        bank_valid_d = bank_valid_q & ~clear_valid;
        load_done_d  = 1'b0;
        cmd_err_d    = 1'b0;
        for (int i = 0; i < N_BANKS; i++) begin
            bank_d[i] = bank_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_ok) begin
                        u_d        = cmd_u;
                        beat_cnt_d = '0;
                    end else begin
                        cmd_err_d  = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (beat_fire && !abort) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (beat_cnt_q == CNT_W'(b)) pack_d[b*BEAT_W +: BEAT_W] = in_data;
                    end
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            S_COMMIT: begin
                for (int i = 0; i < N_BANKS; i++) begin
                    if (u_q == 3'(i)) begin
                        bank_d[i]       = pack_q;
                        bank_valid_d[i] = 1'b1;
                    end
                end
                load_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_q          <= '0;
            beat_cnt_q   <= '0;
            pack_q       <= '0;
            bank_valid_q <= '0;
            load_done_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            for (int i = 0; i < N_BANKS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            u_q          <= u_d;
            beat_cnt_q   <= beat_cnt_d;
            pack_q       <= pack_d;
            bank_valid_q <= bank_valid_d;
            load_done_q  <= load_done_d;
            cmd_err_q    <= cmd_err_d;
            for (int i = 0; i < N_BANKS; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

endmodule

// File: tb/tb_weight_bank_loader_l10_l16.sv
// Scoreboarded bench for weight_bank_loader_l10_l16: a driver issues loads against a
// bank-image model and queues the expected result; a monitor checks each load_done/cmd_err.
module tb_weight_bank_loader_l10_l16;
    localparam int unsigned NW     = 256;
    localparam int unsigned LANES  = 16;
    localparam int unsigned BEATS  = NW / LANES;
    localparam int unsigned BEAT_W = LANES * 16;
    localparam int unsigned BANK_W = NW * 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [2:0]        cmd_u = '0;
    logic              cmd_ready;
    logic              in_valid = 1'b0;
    logic [BEAT_W-1:0] in_data = '0;
    logic              in_ready;
    logic              abort = 1'b0;
    logic [4:0]        clear_valid = '0;
    logic [BANK_W-1:0] weight_out_conv8, weight_out_conv9, weight_out_conv10;
    logic [BANK_W-1:0] weight_out_conv11, weight_out_conv12;
    logic [4:0]        bank_valid;
    logic              busy, load_done, cmd_err;

    weight_bank_loader_l10_l16 #(.N_weight_out(NW), .IN_LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_u(cmd_u), .cmd_ready(cmd_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .abort(abort), .clear_valid(clear_valid),
        .weight_out_conv8(weight_out_conv8), .weight_out_conv9(weight_out_conv9),
        .weight_out_conv10(weight_out_conv10), .weight_out_conv11(weight_out_conv11),
        .weight_out_conv12(weight_out_conv12),
        .bank_valid(bank_valid), .busy(busy), .load_done(load_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [BANK_W-1:0] wo [5];
    assign wo[0] = weight_out_conv8;
    assign wo[1] = weight_out_conv9;
    assign wo[2] = weight_out_conv10;
    assign wo[3] = weight_out_conv11;
    assign wo[4] = weight_out_conv12;

    typedef struct {
        bit                       is_err;
        int                       cyc;
        logic [4:0]               valid;
        logic [4:0][BANK_W-1:0]   imgs;
    } exp_t;

    exp_t                   sbq[$];
    exp_t                   mon_e;
    logic [4:0][BANK_W-1:0] mdl_bank = '0;
    logic [4:0]             mdl_valid = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_bank(input string nm, input logic [BANK_W-1:0] act,
                            input logic [BANK_W-1:0] exp);
        int n;
        total++;
        if (act !== exp) begin
            bad++;
            n = 0;
            while (n < NW - 1 && act[n*16 +: 16] === exp[n*16 +: 16]) n++;
            $display("FAIL %s word%0d act=%04h exp=%04h", nm, n, act[n*16 +: 16], exp[n*16 +: 16]);
        end
    endtask

    // Monitor: every load_done/cmd_err pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && (load_done || cmd_err)) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse load_done=%0b cmd_err=%0b exp=none", load_done, cmd_err);
            end else begin
                mon_e = sbq.pop_front();
                chk("pulse_kind", 32'({load_done, cmd_err}), mon_e.is_err ? 32'd1 : 32'd2);
                chk("pulse_cycle", cyc, mon_e.cyc);
                chk("bank_valid", 32'(bank_valid), 32'(mon_e.valid));
                for (int i = 0; i < 5; i++) chk_bank($sformatf("bank%0d", i), wo[i], mon_e.imgs[i]);
                if (mon_e.is_err) chk("err_busy", 32'(busy), 32'd0);
            end
        end
    end

    function automatic logic [15:0] word_of(input int fill, input int n);
        if (fill == 0)      return 16'(n);
        else if (fill == 1) return 16'hA5A5;
        else                return 16'($urandom);
    endfunction

    task automatic cyc_step();
        mdl_valid = mdl_valid & ~clear_valid;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!cmd_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL idle_timeout cmd_ready=%0b exp=1", cmd_ready);
        end
    endtask

    // mode: 0 gapless, 1 valid toggling, 2 random gaps + random clears
    task automatic do_load(input int u, input int mode, input int fill, input int abort_after,
                           input logic [4:0] commit_clear, input int rst_at);
        logic [BANK_W-1:0] img;
        int   k;
        bit   v, tog, ab, rs;
        exp_t e;
        for (int n = 0; n < NW; n++) img[n*16 +: 16] = word_of(fill, n);
        wait_idle();
        cmd_valid = 1'b1;
        cmd_u     = 3'(u);
        cyc_step();
        cmd_valid = 1'b0;
        cmd_u     = '0;
        chk("load_in_ready", 32'(in_ready), 32'd1);
        k   = 0;
        tog = 1'b1;
        while (k < BEATS) begin
            ab = (abort_after >= 0) && (k == abort_after + 1);
            rs = (rst_at >= 0) && (k == rst_at);
            if (mode == 0 || ab || rs) v = 1'b1;
            else if (mode == 1)        v = tog;
            else                       v = 1'($urandom_range(0, 1));
            tog         = ~tog;
            in_valid    = v;
            in_data     = img[k*BEAT_W +: BEAT_W];
            abort       = ab;
            clear_valid = (mode == 2 && $urandom_range(0, 5) == 0) ? 5'($urandom) : 5'b0;
            if (rs) begin
                rst_n = 1'b0;
                #1;
                mdl_bank  = '0;
                mdl_valid = '0;
                for (int i = 0; i < 5; i++) chk_bank($sformatf("rst_bank%0d", i), wo[i], mdl_bank[i]);
                chk("rst_valid", 32'(bank_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(load_done), 32'd0);
                chk("rst_err", 32'(cmd_err), 32'd0);
                in_valid    = 1'b0;
                clear_valid = '0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
                chk("rel_in_ready", 32'(in_ready), 32'd0);
                return;
            end
            cyc_step();
            abort       = 1'b0;
            clear_valid = '0;
            if (ab) begin
                in_valid = 1'b0;
                chk("abort_busy", 32'(busy), 32'd0);
                chk_bank("abort_bank", wo[u], mdl_bank[u]);
                chk("abort_valid", 32'(bank_valid), 32'(mdl_valid));
                return;
            end
            if (v) k++;
        end
        // DUT is now in its single commit cycle
        in_valid = 1'b0;
        in_data  = '0;
        chk_bank("hold_until_commit", wo[u], mdl_bank[u]);
        chk("commit_busy", 32'(busy), 32'd1);
        clear_valid = commit_clear;
        mdl_valid   = (mdl_valid & ~commit_clear) | (5'b1 << u);
        mdl_bank[u] = img;
        e.is_err = 1'b0;
        e.cyc    = cyc + 1;
        e.valid  = mdl_valid;
        e.imgs   = mdl_bank;
        sbq.push_back(e);
        @(negedge clk);
        clear_valid = '0;
    endtask

    task automatic bad_cmd(input int u);
        exp_t e;
        wait_idle();
        cmd_valid = 1'b1;
        cmd_u     = 3'(u);
        e.is_err = 1'b1;
        e.cyc    = cyc + 1;
        e.valid  = mdl_valid;
        e.imgs   = mdl_bank;
        sbq.push_back(e);
        cyc_step();
        cmd_valid = 1'b0;
        cmd_u     = '0;
        chk("err_busy_after", 32'(busy), 32'd0);
        chk("err_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int ru;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) chk_bank($sformatf("init_bank%0d", i), wo[i], '0);
        chk("init_valid", 32'(bank_valid), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(load_done), 32'd0);
        chk("init_err", 32'(cmd_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("init_in_ready", 32'(in_ready), 32'd0);

        do_load(2, 0, 0, -1, 5'b0, -1);
        do_load(0, 1, 2, -1, 5'b0, -1);
        bad_cmd(5);
        do_load(4, 0, 2, 7, 5'b0, -1);
        do_load(4, 0, 1, -1, 5'b0, -1);
        do_load(1, 0, 2, -1, 5'b00011, -1);

        for (int r = 0; r < 10; r++) begin
            ru = int'($urandom_range(0, 6));
            if (ru > 4) bad_cmd(ru);
            else do_load(ru, 2, 2, -1,
                         ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0, -1);
        end

        do_load(3, 0, 2, -1, 5'b0, 9);
        do_load(3, 0, 2, -1, 5'b0, -1);

        repeat (4) cyc_step();
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
